// File: rtl/ysyx_22050039_ifu_pkg.sv
// Shared IFU types and constants: FSM state encoding, reset PC and instruction width.
package ysyx_22050039_ifu_pkg;

  localparam int          ysyx_22050039_XLEN     = 64;
  localparam int          ysyx_22050039_INST_LEN = 32;
  localparam logic [63:0] ysyx_22050039_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } Ifu_state;

endpackage

// File: rtl/ysyx_22050039_ifu_sel.sv
// Picks the 32-bit instruction word out of a 64-bit memory beat using pc[2].
// Purely combinational, no flow control.
module ysyx_22050039_ifu_sel
  import ysyx_22050039_ifu_pkg::*;
(
  input  logic [63:0]                       beat,
  input  logic                              hi,
  output logic [ysyx_22050039_INST_LEN-1:0] word
);

  assign word = hi ? beat[63:32] : beat[31:0];

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch: PC, one-outstanding imem request, {pc, inst} handoff to decode.
// Best case one instruction per 3 cycles; holds inst until decode takes it, redirects squash.
module ysyx_22050039_ifu
  import ysyx_22050039_ifu_pkg::*;
#(
  parameter int              XLEN     = ysyx_22050039_XLEN,
  parameter int              INST_LEN = ysyx_22050039_INST_LEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ysyx_22050039_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [63:0]         imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc
);

  Ifu_state            state, state_nxt;
  logic [XLEN-1:0]     pc, pc_nxt, redirect_tgt;
  logic                drop, drop_nxt, capture;
  logic [INST_LEN-1:0] sel_word;

  assign redirect_tgt = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  ysyx_22050039_ifu_sel u_sel (
    .beat (imem_resp_data),
    .hi   (pc[2]),
    .word (sel_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      if (capture) begin
        inst    <= sel_word;
        inst_pc <= pc;
      end
    end
  end

  // Redirect always wins the PC; only an unredirected consume in HOLD steps it by 4.
  always_comb begin
    state_nxt = state;
    pc_nxt    = redirect_valid ? redirect_tgt : pc;
    drop_nxt  = drop;
    capture   = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_nxt = WAIT;
          drop_nxt  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          drop_nxt = 1'b0;
          if (drop || redirect_valid) begin
            state_nxt = REQ;
          end else begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end else if (redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_nxt = REQ;
        end else if (inst_ready) begin
          state_nxt = REQ;
          pc_nxt    = pc + XLEN'(4);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == REQ);
    inst_valid     = (state == HOLD);
    imem_req_addr  = (state == REQ) ? {pc[XLEN-1:3], 3'b000} : '0;
  end

endmodule
